vga_mode_seq: RTL and testbench

VGA_MODE_SEQ -- requirements
Module: vga_mode_seq

---
 rtl/vga_mode_seq.sv | 146 ++++++++++++++
 tb/tb_vga_mode_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mode_seq.sv
// vga_mode_seq: sequences VGA mode switches (vsync-aligned quiesce, timing-generator reset, pixel-clock reselect, settle, first-frame blanking); optional switch counter under VGA_MODE_SEQ_STATUS_EN
module vga_mode_seq #(
    parameter int SETTLE_CYCLES = 1024,
    parameter int RST_CYCLES    = 4,
    parameter int VSYNC_TIMEOUT = 2000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mode_req_valid,
    input  logic [1:0] mode_req,
    output logic       mode_req_ready,
    input  logic       vsync_in,
    output logic       tg_reset_n,
    output logic       tg_enable,
    output logic [1:0] clk_sel,
    output logic       blank_force,
    output logic [1:0] mode_cur,
    output logic       busy,
    output logic       err_bad_mode,
    output logic       timeout,
    output logic [7:0] switch_count
);
    typedef enum logic [2:0] {BOOT, RUN, WAIT_VS, QUIESCE, HOLD_RST, SETTLE, START, FIRST_FRAME} state_t;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (VSYNC_TIMEOUT > 1) ? $clog2(VSYNC_TIMEOUT) : 1;
    localparam logic [RW-1:0] RST_LD = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] SET_LD = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LD  = TW'(VSYNC_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [SW-1:0] set_cnt_q, set_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]    tgt_q, tgt_d, sel_q, sel_d;
    logic          err_q, err_d, to_q, to_d;
    logic [2:0]    vs_q;
    logic          vs_fall, accept;

    assign vs_fall        = vs_q[2] & ~vs_q[1];
    assign mode_req_ready = state_q == RUN;
    assign accept         = mode_req_valid & mode_req_ready;
    assign busy           = state_q != RUN;
    assign tg_reset_n     = !(state_q inside {BOOT, HOLD_RST, SETTLE});
    assign tg_enable      = state_q inside {RUN, WAIT_VS, START, FIRST_FRAME};
    assign blank_force    = !(state_q inside {RUN, WAIT_VS});
    assign clk_sel        = sel_q;
    assign mode_cur       = sel_q;
    assign err_bad_mode   = err_q;
    assign timeout        = to_q;

    // State, counters, target/active mode, pulse flags and vsync synchroniser (prev bit for edge detect)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= BOOT;
            rst_cnt_q <= RST_LD;
            set_cnt_q <= '0;
            to_cnt_q  <= '0;
            tgt_q     <= 2'b00;
            sel_q     <= 2'b00;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            vs_q      <= 3'b111;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            set_cnt_q <= set_cnt_d;
            to_cnt_q  <= to_cnt_d;
            tgt_q     <= tgt_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            to_q      <= to_d;
            vs_q      <= {vs_q[1:0], vsync_in};
        end
    end

    // Next-state logic; the clock mux only moves while the timing generator is held in reset
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        set_cnt_d = set_cnt_q;
        to_cnt_d  = to_cnt_q;
        tgt_d     = tgt_q;
        sel_d     = sel_q;
        err_d     = 1'b0;
        to_d      = 1'b0;
        case (state_q)
            BOOT, HOLD_RST: begin
                if (rst_cnt_q == '0) begin
                    state_d   = SETTLE;
                    set_cnt_d = SET_LD;
                    sel_d     = tgt_q;
                end else rst_cnt_d = rst_cnt_q - RW'(1);
            end
            SETTLE: begin
                if (set_cnt_q == '0) state_d = START;
                else set_cnt_d = set_cnt_q - SW'(1);
            end
            START: begin
                state_d  = FIRST_FRAME;
                to_cnt_d = TO_LD;
            end
            RUN: begin
                if (accept && mode_req == 2'b11) err_d = 1'b1;
                else if (accept && mode_req != sel_q) begin
                    tgt_d    = mode_req;
                    state_d  = WAIT_VS;
                    to_cnt_d = TO_LD;
                end
            end
            WAIT_VS, FIRST_FRAME: begin
                if (vs_fall || to_cnt_q == '0) begin
                    state_d = (state_q == WAIT_VS) ? QUIESCE : RUN;
                    to_d    = !vs_fall;
                end else to_cnt_d = to_cnt_q - TW'(1);
            end
            QUIESCE: begin
                state_d   = HOLD_RST;
                rst_cnt_d = RST_LD;
            end
            default: state_d = BOOT;
        endcase
    end

`ifdef VGA_MODE_SEQ_STATUS_EN
    logic [7:0] cnt_q, cnt_d;
    logic       sw_q, sw_d;
    assign sw_d = (state_q == RUN && state_d == WAIT_VS) ? 1'b1 :
                  (state_q == FIRST_FRAME && state_d == RUN) ? 1'b0 : sw_q;
    assign cnt_d = (state_q == FIRST_FRAME && state_d == RUN && sw_q) ? cnt_q + 8'd1 : cnt_q;
    assign switch_count = cnt_q;

    // Counts completed switches; boot completions are excluded via sw_q
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
            sw_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sw_q  <= sw_d;
        end
    end
`else
    assign switch_count = 8'd0;
`endif
endmodule

// File: tb/tb_vga_mode_seq.sv
// tb_vga_mode_seq: directed bench for vga_mode_seq with a mode scoreboard and immediate-assertion checks
module tb_vga_mode_seq;
    localparam int SET = 16;
    localparam int RST = 4;
    localparam int TO  = 200;
`ifdef VGA_MODE_SEQ_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       mode_req_valid = 1'b0;
    logic [1:0] mode_req = 2'b00;
    logic       vsync_in = 1'b1;
    logic       mode_req_ready, tg_reset_n, tg_enable, blank_force, busy, err_bad_mode, timeout;
    logic [1:0] clk_sel, mode_cur;
    logic [7:0] switch_count;
    int         checks = 0;
    int         failures = 0;
    int         rdy_bad = 0;
    logic [1:0] prev_sel = 2'b00;
    logic [1:0] exp_q[$];

    vga_mode_seq #(.SETTLE_CYCLES(SET), .RST_CYCLES(RST), .VSYNC_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .mode_req_valid(mode_req_valid), .mode_req(mode_req),
        .mode_req_ready(mode_req_ready), .vsync_in(vsync_in), .tg_reset_n(tg_reset_n),
        .tg_enable(tg_enable), .clk_sel(clk_sel), .blank_force(blank_force), .mode_cur(mode_cur),
        .busy(busy), .err_bad_mode(err_bad_mode), .timeout(timeout), .switch_count(switch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic vs_pulse();
        vsync_in = 1'b0;
        repeat (3) tick();
        vsync_in = 1'b1;
    endtask

    task automatic wait_sig(input int which, input logic val, input int budget, input string tag);
        logic s;
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            s = (which == 0) ? busy : (which == 1) ? tg_reset_n : tg_enable;
            if (s === val) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pop_check(input string tag);
        logic [1:0] e;
        check({tag, "_sb_nonempty"}, exp_q.size() > 0, 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_mode_cur"}, mode_cur, e);
            check({tag, "_clk_sel"}, clk_sel, e);
        end
    endtask

    // clk_sel may only move while the timing generator is in reset
    always @(negedge clk) begin
        if (clk_sel !== prev_sel) check("clk_sel_change_in_reset", tg_reset_n, 32'd0);
        prev_sel = clk_sel;
        if (reset_n && mode_req_ready !== !busy) rdy_bad++;
    end

    initial begin
        int n;
        repeat (3) tick();
        check("rst_tg_reset_n", tg_reset_n, 0);
        check("rst_tg_enable", tg_enable, 0);
        check("rst_clk_sel", clk_sel, 0);
        check("rst_mode_cur", mode_cur, 0);
        check("rst_blank", blank_force, 1);
        check("rst_busy", busy, 1);
        check("rst_ready", mode_req_ready, 0);
        check("rst_err", err_bad_mode, 0);
        check("rst_timeout", timeout, 0);
        check("rst_count", switch_count, 0);

        exp_q.push_back(2'b00);
        reset_n = 1'b1;
        repeat (RST + SET - 1) tick();
        check("boot_settle_tg_reset_n", tg_reset_n, 0);
        check("boot_settle_busy", busy, 1);
        tick();
        check("boot_start_tg_reset_n", tg_reset_n, 1);
        check("boot_start_tg_enable", tg_enable, 1);
        check("boot_start_blank", blank_force, 1);
        tick();
        check("boot_ff_busy", busy, 1);
        check("boot_ff_blank", blank_force, 1);
        vs_pulse();
        wait_sig(0, 1'b0, 20, "boot_run");
        pop_check("boot");
        check("boot_ready", mode_req_ready, 1);
        check("boot_blank", blank_force, 0);
        check("boot_count", switch_count, 0);

        exp_q.push_back(2'b10);
        mode_req_valid = 1'b1;
        mode_req = 2'b10;
        tick();
        mode_req_valid = 1'b0;
        check("sw10_wait_busy", busy, 1);
        check("sw10_wait_ready", mode_req_ready, 0);
        check("sw10_wait_tg_enable", tg_enable, 1);
        check("sw10_wait_blank", blank_force, 0);
        repeat (5) tick();
        check("sw10_wait_clk_sel", clk_sel, 0);
        vs_pulse();
        check("sw10_quiesce_tg_enable", tg_enable, 0);
        check("sw10_quiesce_blank", blank_force, 1);
        wait_sig(1, 1'b0, 10, "sw10_hold");
        check("sw10_hold_clk_sel", clk_sel, 0);
        wait_sig(2, 1'b1, RST + SET + 10, "sw10_start");
        check("sw10_start_clk_sel", clk_sel, 2'b10);
        check("sw10_start_blank", blank_force, 1);
        repeat (5) tick();
        check("sw10_ff_blank", blank_force, 1);
        check("sw10_ff_busy", busy, 1);
        vs_pulse();
        wait_sig(0, 1'b0, 20, "sw10_run");
        pop_check("sw10");
        check("sw10_blank", blank_force, 0);
        check("sw10_count", switch_count, STAT ? 1 : 0);

        mode_req_valid = 1'b1;
        mode_req = 2'b11;
        tick();
        mode_req_valid = 1'b0;
        check("bad_err_pulse", err_bad_mode, 1);
        check("bad_busy", busy, 0);
        check("bad_mode_cur", mode_cur, 2'b10);
        tick();
        check("bad_err_clear", err_bad_mode, 0);
        mode_req_valid = 1'b1;
        mode_req = 2'b10;
        tick();
        mode_req_valid = 1'b0;
        check("same_busy", busy, 0);
        tick();
        check("same_busy2", busy, 0);
        check("same_err", err_bad_mode, 0);

        exp_q.push_back(2'b01);
        mode_req_valid = 1'b1;
        mode_req = 2'b01;
        tick();
        mode_req_valid = 1'b0;
        n = 0;
        while (timeout !== 1'b1 && n < TO + 10) begin
            tick();
            n++;
        end
        check("to_latency", n, TO);
        tick();
        check("to_pulse_clear", timeout, 0);
        wait_sig(0, 1'b0, RST + SET + TO + 20, "to_run");
        pop_check("to");
        check("to_count", switch_count, STAT ? 2 : 0);

        exp_q.push_back(2'b00);
        mode_req_valid = 1'b1;
        mode_req = 2'b10;
        tick();
        mode_req_valid = 1'b0;
        vs_pulse();
        wait_sig(1, 1'b0, 10, "abort_hold");
        repeat (RST + 2) tick();
        check("abort_settle_clk_sel", clk_sel, 2'b10);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("abort_tg_reset_n", tg_reset_n, 0);
        check("abort_tg_enable", tg_enable, 0);
        check("abort_clk_sel", clk_sel, 0);
        check("abort_mode_cur", mode_cur, 0);
        check("abort_blank", blank_force, 1);
        check("abort_busy", busy, 1);
        check("abort_count", switch_count, 0);
        wait_sig(2, 1'b1, RST + SET + 10, "abort_start");
        vs_pulse();
        wait_sig(0, 1'b0, 20, "abort_run");
        pop_check("abort");
        check("abort_count_after", switch_count, 0);

        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        mode_req_valid = 1'b1;
        mode_req = 2'b01;
        tick();
        mode_req = 2'b10;
        vs_pulse();
        wait_sig(2, 1'b1, RST + SET + 10, "held_start1");
        vs_pulse();
        wait_sig(0, 1'b0, 20, "held_run1");
        pop_check("held1");
        tick();
        mode_req_valid = 1'b0;
        check("held_accept_first_run", busy, 1);
        vs_pulse();
        wait_sig(2, 1'b1, RST + SET + 10, "held_start2");
        vs_pulse();
        wait_sig(0, 1'b0, 20, "held_run2");
        pop_check("held2");
        check("held_count", switch_count, STAT ? 2 : 0);
        check("ready_only_in_run", rdy_bad, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
